alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Drives the ALU operand/opcode interface and consumes its registered result (1-cycle latency).
//  - Accepts one decoded RV32I instruction at a time over a valid/ready handshake.
//  - Selects alu_op, A and B, then presents writeback or branch resolution once the result returns.
//  - Sits between the register-file read stage and the writeback/PC-update logic.
// PARAMETERS
//  XLEN       32  datapath width
//  SUPPORT_BR 1   1: BRANCH opcodes resolved here; 0: BRANCH flagged illegal
// PORTS
//  clk             in   1     core clock, all state on rising edge
//  rst             in   1     asynchronous, active-high reset
//  instr_valid_i   in   1     instruction/operands valid
//  instr_ready_o   out  1     block can accept this cycle
//  instr_i         in   32    raw instruction word
//  pc_i            in   XLEN  PC of instr_i
//  rs1_data_i      in   XLEN  rs1 value
//  rs2_data_i      in   XLEN  rs2 value
//  alu_op_o        out  4     to ALU opcode (alu_op_t)
//  alu_a_o         out  XLEN  to ALU operand A
//  alu_b_o         out  XLEN  to ALU operand B
//  alu_result_i    in   XLEN  from ALU, registered, valid 1 cycle after op/operands
//  wb_valid_o      out  1     1-cycle pulse: instruction retired
//  wb_we_o         out  1     write rd (valid with wb_valid_o)
//  wb_rd_o         out  5     destination register
//  wb_data_o       out  XLEN  writeback value (= alu_result_i)
//  br_taken_o      out  1     branch taken (valid with wb_valid_o)
//  br_target_o     out  XLEN  branch target (= alu_result_i)
//  illegal_o       out  1     unsupported encoding (valid with wb_valid_o)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except instr_ready_o=1; alu_op_o=ADD (0).
//  FSM IDLE -> EXEC -> WB.
//  - IDLE, EXEC: instr_ready_o=1 only in IDLE and WB.
//  - Handshake (valid&ready) at edge T: capture instr/pc/rs1/rs2; drive alu_* registered.
//  - EXEC = cycle T+1; WB = cycle T+2, when wb_valid_o=1.
//  - WB with new handshake -> EXEC (2 cycles/instr sustained); else -> IDLE.
//  ALU ops: ADD=0 AND=1 SLL=2 SRL=3 OR=4 XOR=5 OUT_ONE=6 OUT_ZERO=7 SRA=8 LUI=9 SUB=10.
//  - OP/OP-IMM: funct3 selects; funct7[5]=1 gives SUB (OP only) / SRA; SRLI/SRAI B={27'b0,shamt}.
//  - SLT/SLTU/SLTI/SLTIU: local signed/unsigned compare of A vs B; op=OUT_ONE if less else OUT_ZERO.
//  - LUI: op=LUI, B={12'b0,instr[31:12]} (ALU shifts left 12); AUIPC: ADD, A=pc, B=U-imm.
//  - BRANCH: ADD, A=pc, B=B-imm; taken from local compare (BEQ/BNE/BLT/BGE/BLTU/BGEU) latched in EXEC.
//  - BRANCH WB: wb_we_o=0, br_taken_o/br_target_o valid.
//  - Immediates sign-extended to XLEN.
//  - rd==0: wb_we_o=0.
//  Illegal (unknown opcode, bad funct7, funct3 010/011 on BRANCH, SUPPORT_BR=0 with BRANCH):
//  - ALU op OUT_ZERO.
//  - WB pulses wb_valid_o with illegal_o=1, wb_we_o=0, br_taken_o=0.
//  alu_* outputs hold last value outside EXEC; wb_*/br_*/illegal_o are 0 when wb_valid_o=0.
//  Reset mid-operation drops the in-flight instruction: no wb_valid_o pulse; IDLE next cycle after deassert.
// STRUCTURE
//  riscv_pkg: alu_op_t (4-bit, explicit values above); opcode constants OP, OP_IMM, LUI,
//    AUIPC, BRANCH; funct3 constants.
//  Sub-module imm_gen (combinational I/U/B/shamt extraction), instantiated once.
// TESTING (bench uses a 1-cycle registered ALU model)
//  1. ADDI x5,x0,5 (0x00500293), rs1=0
//     -> EXEC op=ADD a=0 b=5; WB rd=5 data=5 we=1.
//  2. SUB x3,x1,x2 (0x402081B3), rs1=10 rs2=3
//     -> op=SUB(10); WB data=7.
//  3. SLT (0x0020A233) / SLTU (0x0020B233), rs1=0xFFFFFFFF rs2=1
//     -> OUT_ONE, data=1 / OUT_ZERO, data=0.
//  4. BEQ x1,x2,+8 (0x00208463), pc=0x100, rs1=rs2=7
//     -> a=0x100 b=8; br_taken=1 target=0x108 we=0.
//  4b. Same with rs2=8 -> br_taken=0.
//  5. LUI x7,0x12345 (0x123453B7)
//     -> op=LUI b=0x00012345; WB data=0x12345000; opcode 0x7F -> illegal_o=1, we=0.
//  6. valid held over 3 instrs -> accepts every 2 cycles, 3 WB pulses in order.
//  6b. rst pulse in EXEC -> no WB pulse; outputs at reset values; ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ALU opcode encoding used by alu_issue_ctrl.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_AND      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SRL      = 4'd3,
    ALU_OR       = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_OUT_ONE  = 4'd6,
    ALU_OUT_ZERO = 4'd7,
    ALU_SRA      = 4'd8,
    ALU_LUI      = 4'd9,
    ALU_SUB      = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Shift encodings carry funct7 in the upper immediate bits, which must be checked.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_imm_gen.sv
// Combinational immediate extraction for RV32I I/U/B formats and shift amounts.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  output logic [XLEN-1:0] imm_itype,
  output logic [XLEN-1:0] imm_utype,
  output logic [XLEN-1:0] imm_btype,
  output logic [XLEN-1:0] imm_shamt,
  output logic [XLEN-1:0] imm_lui
);

  assign imm_itype = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign imm_utype = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
  assign imm_btype = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
  // The ALU performs the <<12 for LUI, so only the raw upper field is passed on.
  assign imm_lui   = {{(XLEN-20){1'b0}}, instr[31:12]};

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one RV32I ALU/branch instruction at a time to a 1-cycle registered ALU and
// presents writeback / branch resolution when the result returns.
module alu_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SUPPORT_BR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output alu_op_t         alu_op_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            br_taken_o,
  output logic [XLEN-1:0] br_target_o,
  output logic            illegal_o,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer happens on a rising edge where instr_valid_i and instr_ready_o
  // are both high; instr_ready_o is high only in IDLE and WB, and is itself registered.
  state_t state;
  logic   accept;
  assign accept    = instr_valid_i && instr_ready_o;
  assign dbg_state = state;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  assign opc = instr_i[6:0];
  assign rd  = instr_i[11:7];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  logic [XLEN-1:0] imm_itype, imm_utype, imm_btype, imm_shamt, imm_lui;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr     (instr_i[31:7]),
    .imm_itype (imm_itype),
    .imm_utype (imm_utype),
    .imm_btype (imm_btype),
    .imm_shamt (imm_shamt),
    .imm_lui   (imm_lui)
  );

  logic            is_imm, is_shift, alt;
  logic [XLEN-1:0] opnd_b;
  assign is_imm   = (opc == OPC_OP_IMM);
  assign is_shift = is_shift_f3(f3);
  assign alt      = (f7 == F7_ALT);
  assign opnd_b   = !is_imm ? rs2_data_i : (is_shift ? imm_shamt : imm_itype);

  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_wr, dec_branch, dec_illegal;

  always_comb begin
    dec_op      = ALU_ADD;
    dec_a       = rs1_data_i;
    dec_b       = opnd_b;
    dec_wr      = 1'b1;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM: begin
        // funct7 only matters for register ops and immediate shifts; ALT is SUB/SRA only.
        if ((!is_imm || is_shift) && (f7 != F7_BASE) &&
            !(alt && ((f3 == F3_SRL_SRA) || ((f3 == F3_ADD_SUB) && !is_imm))))
          dec_illegal = 1'b1;
        case (f3)
          F3_ADD_SUB: if (alt && !is_imm) dec_op = ALU_SUB; else dec_op = ALU_ADD;
          F3_SLL:     dec_op = ALU_SLL;
          F3_SLT:     if ($signed(rs1_data_i) < $signed(opnd_b)) dec_op = ALU_OUT_ONE;
                      else dec_op = ALU_OUT_ZERO;
          F3_SLTU:    if (rs1_data_i < opnd_b) dec_op = ALU_OUT_ONE;
                      else dec_op = ALU_OUT_ZERO;
          F3_XOR:     dec_op = ALU_XOR;
          F3_SRL_SRA: if (alt) dec_op = ALU_SRA; else dec_op = ALU_SRL;
          F3_OR:      dec_op = ALU_OR;
          F3_AND:     dec_op = ALU_AND;
          default:    dec_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_op = ALU_LUI;
        dec_a  = '0;
        dec_b  = imm_lui;
      end
      OPC_AUIPC: begin
        dec_a = pc_i;
        dec_b = imm_utype;
      end
      OPC_BRANCH: begin
        dec_a      = pc_i;
        dec_b      = imm_btype;
        dec_wr     = 1'b0;
        dec_branch = 1'b1;
        if (!SUPPORT_BR || (f3 == F3_SLT) || (f3 == F3_SLTU))
          dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op     = ALU_OUT_ZERO;
      dec_wr     = 1'b0;
      dec_branch = 1'b0;
    end
    if (rd == 5'd0)
      dec_wr = 1'b0;
  end

  logic            wr_q, branch_q, illegal_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            taken;

  always_comb begin
    taken = 1'b0;
    case (f3_q)
      F3_BEQ:  taken = (rs1_q == rs2_q);
      F3_BNE:  taken = (rs1_q != rs2_q);
      F3_BLT:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      F3_BGE:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: taken = (rs1_q <  rs2_q);
      F3_BGEU: taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      instr_ready_o <= 1'b1;
      alu_op_o      <= ALU_ADD;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      wb_valid_o    <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_rd_o       <= '0;
      br_taken_o    <= 1'b0;
      illegal_o     <= 1'b0;
      wr_q          <= 1'b0;
      branch_q      <= 1'b0;
      illegal_q     <= 1'b0;
      rd_q          <= '0;
      f3_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
    end else begin
      if (accept) begin
        alu_op_o  <= dec_op;
        alu_a_o   <= dec_a;
        alu_b_o   <= dec_b;
        wr_q      <= dec_wr;
        branch_q  <= dec_branch;
        illegal_q <= dec_illegal;
        rd_q      <= rd;
        f3_q      <= f3;
        rs1_q     <= rs1_data_i;
        rs2_q     <= rs2_data_i;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_EXEC;
            instr_ready_o <= 1'b0;
          end
        end
        ST_EXEC: begin
          state         <= ST_WB;
          instr_ready_o <= 1'b1;
          wb_valid_o    <= 1'b1;
          wb_we_o       <= wr_q;
          wb_rd_o       <= rd_q;
          br_taken_o    <= branch_q && taken;
          illegal_o     <= illegal_q;
        end
        ST_WB: begin
          wb_valid_o <= 1'b0;
          wb_we_o    <= 1'b0;
          wb_rd_o    <= '0;
          br_taken_o <= 1'b0;
          illegal_o  <= 1'b0;
          if (accept) begin
            state         <= ST_EXEC;
            instr_ready_o <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state         <= ST_IDLE;
          instr_ready_o <= 1'b1;
        end
      endcase
    end
  end

  // The ALU result arrives in WB, so data and target pass straight through, gated by the pulse.
  assign wb_data_o   = wb_valid_o ? alu_result_i : '0;
  assign br_target_o = wb_valid_o ? alu_result_i : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed RV32I cases plus randomized traffic checked
// against an ISA-level result model, with a 1-cycle registered ALU behind the DUT.
module tb_alu_issue_ctrl;

  localparam int EW = 40; // {illegal, taken, we, rd[4:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        wb_valid_o, wb_we_o, br_taken_o, illegal_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o, br_target_o;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .alu_op_o      (alu_op),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_result_i  (alu_result),
    .wb_valid_o    (wb_valid_o),
    .wb_we_o       (wb_we_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .br_taken_o    (br_taken_o),
    .br_target_o   (br_target_o),
    .illegal_o     (illegal_o),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / ALU ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a & b;
      4'd2:    return a << b[4:0];
      4'd3:    return a >> b[4:0];
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return 32'd1;
      4'd7:    return 32'd0;
      4'd8:    return 32'($signed(a) >>> b[4:0]);
      4'd9:    return b << 12;
      4'd10:   return a - b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_fn(alu_op, alu_a, alu_b);

  // ---------------- ISA-level reference model ----------------
  function automatic logic [EW-1:0] ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                              input logic [31:0] r1, input logic [31:0] r2);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] iimm, uimm, bimm, opb, res;
    logic        ill, tk, we, imm, shift;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    rd   = ins[11:7];
    iimm = {{20{ins[31]}}, ins[31:20]};
    uimm = {ins[31:12], 12'b0};
    bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ill = 1'b0; tk = 1'b0; res = 32'd0;
    case (opc)
      7'h33, 7'h13: begin
        imm   = (opc == 7'h13);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        opb   = imm ? (shift ? {27'b0, ins[24:20]} : iimm) : r2;
        if ((!imm || shift) && f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd5 || (f3 == 3'd0 && !imm))))
          ill = 1'b1;
        case (f3)
          3'd0: res = (!imm && f7 == 7'h20) ? r1 - opb : r1 + opb;
          3'd1: res = r1 << opb[4:0];
          3'd2: res = ($signed(r1) < $signed(opb)) ? 32'd1 : 32'd0;
          3'd3: res = (r1 < opb) ? 32'd1 : 32'd0;
          3'd4: res = r1 ^ opb;
          3'd5: res = (f7 == 7'h20) ? 32'($signed(r1) >>> opb[4:0]) : r1 >> opb[4:0];
          3'd6: res = r1 | opb;
          default: res = r1 & opb;
        endcase
      end
      7'h37: res = uimm;
      7'h17: res = pc + uimm;
      7'h63: begin
        res = pc + bimm;
        case (f3)
          3'd0: tk = (r1 == r2);
          3'd1: tk = (r1 != r2);
          3'd4: tk = ($signed(r1) <  $signed(r2));
          3'd5: tk = ($signed(r1) >= $signed(r2));
          3'd6: tk = (r1 <  r2);
          3'd7: tk = (r1 >= r2);
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    we = !ill && (opc != 7'h63) && (rd != 5'd0);
    if (ill) begin
      res = 32'd0;
      tk  = 1'b0;
    end
    return {ill, tk, we, rd, res};
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k2;
    w  = $urandom();
    k2 = $urandom_range(0, 3);
    case ($urandom_range(0, 9))
      0, 1: begin
        w[6:0]   = 7'h33;
        w[31:25] = (k2 == 0) ? 7'($urandom()) : ((k2 == 1) ? 7'h20 : 7'h00);
      end
      2, 3: begin
        w[6:0] = 7'h13;
        if (w[13:12] == 2'b01)
          w[31:25] = (k2 == 0) ? 7'($urandom()) : ((k2 == 1) ? 7'h20 : 7'h00);
      end
      4:       w[6:0] = 7'h37;
      5:       w[6:0] = 7'h17;
      6, 7:    w[6:0] = 7'h63;
      default: w = w;
    endcase
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Returns #1 after the accepting edge; instr_valid_i is left high for the caller.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    int n;
    n = 0;
    instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    instr_valid_i = 1'b1;
    while (!instr_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!instr_ready_o) begin
      bad++;
      $display("FAIL drive_ready_timeout: ready=%0b after %0d cycles, required 1", instr_ready_o, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, output logic [3:0] op, output logic [31:0] a,
                       output logic [31:0] b, output logic [EW-1:0] wb, output logic [31:0] tgt,
                       output bit got);
    @(negedge clk);
    drive(ins, pc, r1, r2);
    op = alu_op; a = alu_a; b = alu_b;
    instr_valid_i = 1'b0;
    wb = '0; tgt = '0; got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (wb_valid_o) begin
        got = 1'b1;
        wb  = {illegal_o, br_taken_o, wb_we_o, wb_rd_o, wb_data_o};
        tgt = br_target_o;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    instr_valid_i = 1'b0;
    instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    repeat (3) @(negedge clk);
    total++;
    if (instr_ready_o !== 1'b1 || dbg_state !== 2'd0 || alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%0b state=%0d op=%0d a=%h b=%h, required 1 0 0 0 0",
               instr_ready_o, dbg_state, alu_op, alu_a, alu_b);
    end
    total++;
    if ({wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, br_taken_o, br_target_o, illegal_o} !== '0) begin
      bad++;
      $display("FAIL reset_wb: valid=%0b we=%0b rd=%0d data=%h tk=%0b tgt=%h ill=%0b, required all 0",
               wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, br_taken_o, br_target_o, illegal_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0] op; logic [31:0] a, b, tgt; logic [EW-1:0] wb; bit got;
    issue(32'h0050_0293, 32'h0, 32'h0, 32'h0, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd0 || a !== 32'd0 || b !== 32'd5) begin
      bad++;
      $display("FAIL addi_exec: op=%0d a=%h b=%h, required op=0 a=0 b=5", op, a, b);
    end
    total++;
    if (!got || wb !== {1'b0, 1'b0, 1'b1, 5'd5, 32'd5}) begin
      bad++;
      $display("FAIL addi_wb: got=%0b wb=%h, required rd=5 data=5 we=1", got, wb);
    end
  endtask

  task automatic test_sub();
    logic [3:0] op; logic [31:0] a, b, tgt; logic [EW-1:0] wb; bit got;
    issue(32'h4020_81B3, 32'h0, 32'd10, 32'd3, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd10 || a !== 32'd10 || b !== 32'd3) begin
      bad++;
      $display("FAIL sub_exec: op=%0d a=%h b=%h, required op=10 a=a b=3", op, a, b);
    end
    total++;
    if (!got || wb !== {1'b0, 1'b0, 1'b1, 5'd3, 32'd7}) begin
      bad++;
      $display("FAIL sub_wb: got=%0b wb=%h, required rd=3 data=7 we=1", got, wb);
    end
  endtask

  task automatic test_slt();
    logic [3:0] op; logic [31:0] a, b, tgt; logic [EW-1:0] wb; bit got;
    issue(32'h0020_A233, 32'h0, 32'hFFFF_FFFF, 32'd1, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd6 || !got || wb[31:0] !== 32'd1 || wb[37] !== 1'b1) begin
      bad++;
      $display("FAIL slt: op=%0d got=%0b data=%h we=%0b, required op=6 data=1 we=1", op, got, wb[31:0], wb[37]);
    end
    issue(32'h0020_B233, 32'h0, 32'hFFFF_FFFF, 32'd1, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd7 || !got || wb[31:0] !== 32'd0 || wb[37] !== 1'b1) begin
      bad++;
      $display("FAIL sltu: op=%0d got=%0b data=%h we=%0b, required op=7 data=0 we=1", op, got, wb[31:0], wb[37]);
    end
  endtask

  task automatic test_branch();
    logic [3:0] op; logic [31:0] a, b, tgt; logic [EW-1:0] wb; bit got;
    issue(32'h0020_8463, 32'h100, 32'd7, 32'd7, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd0 || a !== 32'h100 || b !== 32'd8) begin
      bad++;
      $display("FAIL beq_exec: op=%0d a=%h b=%h, required op=0 a=100 b=8", op, a, b);
    end
    total++;
    if (!got || wb[39:37] !== 3'b010 || tgt !== 32'h108 || wb[31:0] !== 32'h108) begin
      bad++;
      $display("FAIL beq_taken: got=%0b ill/tk/we=%b tgt=%h, required 010 tgt=108", got, wb[39:37], tgt);
    end
    issue(32'h0020_8463, 32'h100, 32'd7, 32'd8, op, a, b, wb, tgt, got);
    total++;
    if (!got || wb[39:37] !== 3'b000 || tgt !== 32'h108) begin
      bad++;
      $display("FAIL beq_not_taken: got=%0b ill/tk/we=%b tgt=%h, required 000 tgt=108", got, wb[39:37], tgt);
    end
  endtask

  task automatic test_lui_illegal();
    logic [3:0] op; logic [31:0] a, b, tgt; logic [EW-1:0] wb; bit got;
    issue(32'h1234_53B7, 32'h0, 32'h0, 32'h0, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd9 || b !== 32'h0001_2345) begin
      bad++;
      $display("FAIL lui_exec: op=%0d b=%h, required op=9 b=00012345", op, b);
    end
    total++;
    if (!got || wb !== {1'b0, 1'b0, 1'b1, 5'd7, 32'h1234_5000}) begin
      bad++;
      $display("FAIL lui_wb: got=%0b wb=%h, required rd=7 data=12345000 we=1", got, wb);
    end
    issue(32'h0000_007F, 32'h0, 32'd9, 32'd9, op, a, b, wb, tgt, got);
    total++;
    if (op !== 4'd7 || !got || wb[39:37] !== 3'b100) begin
      bad++;
      $display("FAIL illegal_opcode: op=%0d got=%0b ill/tk/we=%b, required op=7 100", op, got, wb[39:37]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[3];
    logic [31:0] r1[3];
    logic [31:0] r2[3];
    int          hs[3];
    int          seen;
    ins = '{32'h0050_0293, 32'h4020_81B3, 32'h1234_53B7};
    r1  = '{32'd0, 32'd10, 32'd0};
    r2  = '{32'd0, 32'd3, 32'd0};
    seen = 0;
    exp_q.delete();
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          drive(ins[i], 32'h40, r1[i], r2[i]);
          hs[i] = cyc;
          exp_q.push_back(ref_model(ins[i], 32'h40, r1[i], r2[i]));
        end
        instr_valid_i = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && seen < 3; c++) begin
          @(negedge clk);
          if (wb_valid_o) begin
            logic [EW-1:0] e;
            seen++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            total++;
            if ({illegal_o, br_taken_o, wb_we_o, wb_rd_o, wb_data_o} !== e) begin
              bad++;
              $display("FAIL b2b_wb%0d: got=%h required=%h", seen, {illegal_o, br_taken_o, wb_we_o, wb_rd_o, wb_data_o}, e);
            end
          end
        end
      end
    join
    total++;
    if (seen != 3 || hs[1] - hs[0] != 2 || hs[2] - hs[1] != 2) begin
      bad++;
      $display("FAIL b2b_rate: pulses=%0d gaps=%0d,%0d, required 3 pulses gaps 2,2", seen, hs[1] - hs[0], hs[2] - hs[1]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    drive(32'h0050_0293, 32'h0, 32'h0, 32'h0);
    instr_valid_i = 1'b0;
    rst = 1'b1;
    #2;
    total++;
    if (instr_ready_o !== 1'b1 || dbg_state !== 2'd0 || alu_op !== 4'd0 || alu_a !== 32'd0 ||
        alu_b !== 32'd0 || wb_valid_o !== 1'b0 || wb_data_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_values: ready=%0b state=%0d op=%0d a=%h b=%h wbv=%0b, required 1 0 0 0 0 0",
               instr_ready_o, dbg_state, alu_op, alu_a, alu_b, wb_valid_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid_o) pulses++;
    end
    total++;
    if (pulses != 0 || instr_ready_o !== 1'b1 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_drop: pulses=%0d ready=%0b state=%0d, required 0 1 0", pulses, instr_ready_o, dbg_state);
    end
  endtask

  task automatic test_random();
    int n_tx;
    int seen;
    n_tx = 150;
    seen = 0;
    exp_q.delete();
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < n_tx; i++) begin
          logic [31:0] ins, pc, r1, r2;
          ins = rand_instr();
          pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
          r1  = rand_data();
          r2  = ($urandom_range(0, 3) == 0) ? r1 : rand_data();
          drive(ins, pc, r1, r2);
          exp_q.push_back(ref_model(ins, pc, r1, r2));
          if ($urandom_range(0, 2) == 0) begin
            instr_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
          end
        end
        instr_valid_i = 1'b0;
      end
      begin
        for (int c = 0; c < n_tx * 6 + 50 && seen < n_tx; c++) begin
          @(negedge clk);
          if (wb_valid_o) begin
            logic [EW-1:0] e, act;
            seen++;
            e   = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            act = {illegal_o, br_taken_o, wb_we_o, wb_rd_o, wb_data_o};
            total++;
            if ({act[39:37], act[31:0]} !== {e[39:37], e[31:0]} || (e[37] && act[36:32] !== e[36:32]) ||
                br_target_o !== e[31:0]) begin
              bad++;
              $display("FAIL rand_wb%0d: got=%h tgt=%h required=%h", seen, act, br_target_o, e);
            end
          end else begin
            total++;
            if ({wb_we_o, wb_rd_o, wb_data_o, br_taken_o, br_target_o, illegal_o} !== '0) begin
              bad++;
              $display("FAIL rand_idle_zero: we=%0b rd=%0d data=%h tk=%0b tgt=%h ill=%0b, required all 0",
                       wb_we_o, wb_rd_o, wb_data_o, br_taken_o, br_target_o, illegal_o);
            end
          end
        end
      end
    join
    total++;
    if (seen != n_tx || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_count: pulses=%0d left=%0d, required %0d and 0", seen, exp_q.size(), n_tx);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_slt();
    test_branch();
    test_lui_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
